lc3_ir_encoder: RTL and testbench
=================================

LC3_IR_ENCODER -- requirements
Module: lc3_ir_encoder

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 SHALL have ports:
  in_valid  input 1  request word present
  in_ready  output 1  encoder accepts request
  opcode  input 4  placed in ir[15:12]
  fmt  input 3  field format (enum in lc3_pkg)
  dr  input 3  DR, SR or nzp field
  sr1  input 3  SR1 or BaseR field
  value  input 16  signed offset, immediate, SR2 or trapvect
  ir_out  output 16  packed instruction word
  out_valid  output 1  ir_out valid
  out_ready  input 1  consumer accepts ir_out
  err_pulse  output 1  one-cycle pulse when a request is dropped
  err_count  output 8  saturating count of dropped requests
REQ-003 SHALL have no parameters; FIFO depth is fixed at 2.

Function
REQ-004 Formats and fit rules: OFF11 value[15:10] all equal; OFF9 value[15:8] equal; OFF6 value[15:5] equal; IMM5 value[15:4] equal; REG always fits; TRAP8 value[15:8]==0; fmt codes 6 and 7 are reserved and never fit.
REQ-005 Packing, with opcode always in [15:12]: OFF11 [11]=1, [10:0]=value[10:0]; OFF9 [11:9]=dr, [8:0]=value[8:0]; OFF6 [11:9]=dr, [8:6]=sr1, [5:0]=value[5:0]; IMM5 [11:9]=dr, [8:6]=sr1, [5]=1, [4:0]=value[4:0]; REG [11:9]=dr, [8:6]=sr1, [5:3]=000, [2:0]=value[2:0]; TRAP8 [11:8]=0000, [7:0]=value[7:0].
REQ-006 Accept occurs when in_valid && in_ready at a rising edge; inputs are captured into stage-1 register (s1) with a computed fit flag.
REQ-007 s1 advances when s1 is valid and either its fit flag is 0 (dropped) or the registered FIFO count is less than 2 (packed word is written).
REQ-008 in_ready = !s1_valid || s1 advances; in_ready SHALL have no combinational path from out_ready.
REQ-009 Latency: a fitting word accepted at edge N is written to the FIFO at edge N+1; out_valid is high after edge N+1 when the FIFO was empty.
REQ-010 ir_out always shows the FIFO head and holds stable while out_valid && !out_ready.
REQ-011 A pop occurs on out_valid && out_ready; a simultaneous push and pop at count 1 leaves the count at 1; a push at count 2 never occurs.
REQ-012 A dropped word asserts err_pulse for exactly the cycle after the edge at which it leaves s1.
REQ-013 A dropped word increments err_count, which saturates at 255.
REQ-014 Output order SHALL equal acceptance order for all words that fit.
REQ-015 Back-to-back accepts SHALL sustain one word per cycle while out_ready=1.

Reset
REQ-016 While reset is high at an edge: s1_valid=0, FIFO count=0, out_valid=0, err_pulse=0, err_count=0, ir_out=0x0000.
REQ-017 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-018 Reset mid-operation discards s1 and FIFO contents; no partial word is emitted afterwards.

Structure
REQ-019 lc3_pkg SHALL hold the fmt enum (OFF11=0, OFF9=1, OFF6=2, IMM5=3, REG=4, TRAP8=5) and the field-width constants 11/9/6/5/8.
REQ-020 The 2-entry 16-bit FIFO SHALL be the sub-module lc3_ir_fifo2, using the same clk and reset.
REQ-021 Fit check and packing SHALL be combinational logic ahead of s1 or the FIFO write; no other sub-modules.

Verification
REQ-022 LD: opcode=0x2, fmt=OFF9, dr=2, value=0xFFFF -> ir_out=0x25FF with out_valid two cycles after the accept cycle.
REQ-023 ADD imm: opcode=0x1, fmt=IMM5, dr=1, sr1=2, value=0xFFF0 -> 0x12B0; JSR: opcode=0x4, fmt=OFF11, value=0x03FF -> 0x4BFF; TRAP: opcode=0xF, fmt=TRAP8, value=0x0025 -> 0xF025.
REQ-024 Range error: fmt=IMM5, value=0x0010 -> no output word, err_pulse one cycle, err_count=1; after 300 such requests err_count=255.
REQ-025 Backpressure: out_ready=0, three fitting requests -> two held in FIFO, third in s1, in_ready=0; then out_ready=1 -> three words in order, in_ready returns to 1.
REQ-026 Reset asserted with a full FIFO and s1 valid -> out_valid=0 next cycle and err_count=0; no stale word after release.
REQ-027 Reserved fmt=6 with any value -> dropped and err_pulse asserted; a fitting word that follows it is emitted unaffected.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 instruction encoder: field formats,
// field widths, and the fit-check / packing helpers.
package lc3_pkg;

  typedef enum logic [2:0] {
    OFF11 = 3'd0,
    OFF9  = 3'd1,
    OFF6  = 3'd2,
    IMM5  = 3'd3,
    REG   = 3'd4,
    TRAP8 = 3'd5
  } fmt_e;

  localparam int W_OFF11 = 11;
  localparam int W_OFF9  = 9;
  localparam int W_OFF6  = 6;
  localparam int W_IMM5  = 5;
  localparam int W_TRAP8 = 8;

  typedef struct packed {
    logic        fit;
    logic [15:0] ir;
  } s1_t;

  // Signed fit: bits [15:w-1] must all be copies of the sign bit.
  function automatic logic sfits(input logic [15:0] v, input int w);
    logic [15:0] m;
    m = 16'hFFFF << (w - 1);
    return ((v & m) == 16'h0000) || ((v & m) == m);
  endfunction

  function automatic logic fits(input logic [2:0] fmt, input logic [15:0] v);
    case (fmt)
      OFF11:   return sfits(v, W_OFF11);
      OFF9:    return sfits(v, W_OFF9);
      OFF6:    return sfits(v, W_OFF6);
      IMM5:    return sfits(v, W_IMM5);
      REG:     return 1'b1;
      TRAP8:   return (v >> W_TRAP8) == 16'h0000;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] op, input logic [2:0] fmt,
                                       input logic [2:0] dr, input logic [2:0] sr1,
                                       input logic [15:0] v);
    logic [11:0] lo;
    case (fmt)
      OFF11:   lo = {1'b1, v[10:0]};
      OFF9:    lo = {dr, v[8:0]};
      OFF6:    lo = {dr, sr1, v[5:0]};
      IMM5:    lo = {dr, sr1, 1'b1, v[4:0]};
      REG:     lo = {dr, sr1, 3'b000, v[2:0]};
      TRAP8:   lo = {4'h0, v[7:0]};
      default: lo = 12'h000;
    endcase
    return {op, lo};
  endfunction

endpackage

// File: rtl/lc3_ir_fifo2.sv
// Two-entry 16-bit FIFO; head is always visible on dout, count is registered.
module lc3_ir_fifo2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic [1:0]  count
);

  logic [1:0][15:0] mem;
  logic             wp, rp;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/lc3_ir_encoder.sv
// LC-3 instruction word encoder: fit-check and pack into s1, then push
// fitting words into a 2-deep FIFO; words that do not fit are dropped and counted.
module lc3_ir_encoder
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  fmt,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [15:0] value,
  output logic [15:0] ir_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  s1_t        s1_q, s1_d;
  logic       s1_valid;
  logic [1:0] fcnt;
  logic       room, s1_adv, push, pop, drop;

  always_comb begin
    s1_d     = '0;
    s1_d.fit = fits(fmt, value);
    s1_d.ir  = pack(opcode, fmt, dr, sr1, value);
  end

  // fcnt is registered, so in_ready never depends on out_ready this cycle.
  assign room     = fcnt < 2'd2;
  assign s1_adv   = s1_valid && (!s1_q.fit || room);
  assign push     = s1_valid && s1_q.fit && room;
  assign drop     = s1_valid && !s1_q.fit;
  assign in_ready = !s1_valid || s1_adv;
  assign out_valid = fcnt != 2'd0;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      err_pulse <= drop;
      if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  lc3_ir_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (s1_q.ir),
    .pop   (pop),
    .dout  (ir_out),
    .count (fcnt)
  );

endmodule

// File: tb/tb_lc3_ir_encoder.sv
// Directed bench for lc3_ir_encoder with hand-computed instruction words.
module tb_lc3_ir_encoder;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  fmt = '0;
  logic [2:0]  dr = '0;
  logic [2:0]  sr1 = '0;
  logic [15:0] value = '0;
  logic [15:0] ir_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_pulse;
  logic [7:0]  err_count;

  int ncmp = 0;
  int nmis = 0;
  int pulses = 0;
  int p0;
  logic [15:0] got_q[$];

  lc3_ir_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .fmt(fmt), .dr(dr), .sr1(sr1), .value(value),
    .ir_out(ir_out), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(ir_out);
    if (err_pulse) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] f, input logic [2:0] d,
                       input logic [2:0] s, input logic [15:0] v);
    in_valid = 1'b1;
    opcode = op; fmt = f; dr = d; sr1 = s; value = v;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input string tag, input logic [3:0] op, input logic [2:0] f,
                      input logic [2:0] d, input logic [2:0] s, input logic [15:0] v);
    int i;
    drive(op, f, d, s, v);
    for (i = 0; i < 20 && !in_ready; i++) step();
    if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
    step();
  endtask

  task automatic wait_word(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 20 && got_q.size() == 0; i++) step();
    if (got_q.size() == 0) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, got_q.pop_front(), exp);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ir_out", ir_out, 16'h0000);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // Single range error: IMM5 value 16 does not fit
    drive(4'h1, IMM5, 3'd1, 3'd2, 16'h0010);
    step();
    in_valid = 1'b0;
    chk("rng_pulse_pre", err_pulse, 0);
    step();
    chk("rng_pulse", err_pulse, 1);
    chk("rng_count", err_count, 1);
    chk("rng_no_word", out_valid, 0);
    step();
    chk("rng_pulse_end", err_pulse, 0);

    // LD latency: out_valid two cycles after accept
    drive(4'h2, OFF9, 3'd2, 3'd0, 16'hFFFF);
    step();
    in_valid = 1'b0;
    chk("ld_early", out_valid, 0);
    step();
    chk("ld_valid", out_valid, 1);
    chk("ld_word", ir_out, 16'h25FF);
    step();
    got_q.delete();

    // Back-to-back ADD imm, JSR, TRAP at one per cycle
    drive(4'h1, IMM5, 3'd1, 3'd2, 16'hFFF0);
    chk("b2b_rdy0", in_ready, 1);
    step();
    drive(4'h4, OFF11, 3'd0, 3'd0, 16'h03FF);
    chk("b2b_rdy1", in_ready, 1);
    step();
    drive(4'hF, TRAP8, 3'd0, 3'd0, 16'h0025);
    chk("b2b_rdy2", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_word("add_imm", 16'h12B0);
    wait_word("jsr", 16'h4BFF);
    wait_word("trap", 16'hF025);

    // Reserved format and TRAP8 overflow are dropped; next word is unaffected
    p0 = pulses;
    send("rsv", 4'h0, 3'd6, 3'd0, 3'd0, 16'h0000);
    in_valid = 1'b0;
    step();
    chk("rsv_pulse", err_pulse, 1);
    chk("rsv_count", err_count, 2);
    send("trap_big", 4'hF, TRAP8, 3'd0, 3'd0, 16'h0100);
    send("jsr_neg", 4'h4, OFF11, 3'd0, 3'd0, 16'hFC00);
    in_valid = 1'b0;
    wait_word("jsr_neg_word", 16'h4C00);
    step();
    chk("drop_count", err_count, 3);
    chk("drop_pulses", pulses - p0, 2);
    chk("drop_no_extra", got_q.size(), 0);

    // Backpressure: two held in FIFO, third stalled in s1
    out_ready = 1'b0;
    send("bp_a", 4'h6, OFF6, 3'd3, 3'd4, 16'hFFE0);
    send("bp_b", 4'h1, REG, 3'd7, 3'd5, 16'h0006);
    send("bp_c", 4'h0, OFF9, 3'd5, 3'd0, 16'hFF00);
    in_valid = 1'b0;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", ir_out, 16'h6720);
    step(); step();
    chk("bp_hold", ir_out, 16'h6720);
    chk("bp_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    wait_word("bp_w0", 16'h6720);
    wait_word("bp_w1", 16'h1F46);
    wait_word("bp_w2", 16'h0B00);
    chk("bp_in_ready_back", in_ready, 1);

    // Reset with full FIFO and s1 valid
    out_ready = 1'b0;
    send("mr_a", 4'h6, OFF6, 3'd3, 3'd4, 16'hFFE0);
    send("mr_b", 4'h1, REG, 3'd7, 3'd5, 16'h0006);
    send("mr_c", 4'h0, OFF9, 3'd5, 3'd0, 16'hFF00);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("mr_out_valid", out_valid, 0);
    chk("mr_err_count", err_count, 0);
    chk("mr_ir_out", ir_out, 16'h0000);
    reset = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    repeat (6) step();
    chk("mr_no_stale", got_q.size(), 0);

    // Saturation: 300 dropped requests
    p0 = pulses;
    drive(4'h1, IMM5, 3'd1, 3'd2, 16'h0010);
    repeat (300) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("sat_count", err_count, 8'd255);
    chk("sat_pulses", pulses - p0, 300);
    chk("sat_no_word", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
